// File: rtl/fc_bias_sequencer.sv
// fc_bias_sequencer: walks FC output tiles, adds per-tile bias
// to MAC accumulators with signed saturation, streams to activation.
module fc_bias_sequencer #(
  parameter int NUM_LANES  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_TILES  = 64,
  parameter int ADDR_WIDTH = $clog2(MAX_TILES),
  parameter int TILE_W     = $clog2(MAX_TILES+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [TILE_W-1:0]              num_tiles,
  output logic                           busy,
  output logic                           done,
  output logic                           rom_en,
  output logic [ADDR_WIDTH-1:0]          rom_addr,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] rom_data,
  input  logic                           acc_valid,
  output logic                           acc_ready,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] acc_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0] out_data
);

  localparam int VW = NUM_LANES*ACC_WIDTH;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, WAIT_ACC, OUTPUT, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] tile_q, tile_d;
  logic [TILE_W-1:0]     num_q, num_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [VW-1:0]         bias_q, bias_d;
  logic                  out_valid_q, out_valid_d;
  logic [VW-1:0]         out_data_q, out_data_d;
  logic [VW-1:0]         sum;
  logic                  last_tile;

  function automatic logic [ACC_WIDTH-1:0] sat_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_add = s[ACC_WIDTH-1:0];
  endfunction

  // lane-wise saturating bias + accumulator
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      sum[i*ACC_WIDTH +: ACC_WIDTH] =
        sat_add(bias_q[i*ACC_WIDTH +: ACC_WIDTH],
                acc_data[i*ACC_WIDTH +: ACC_WIDTH]);
  end

  assign last_tile = (TILE_W'(tile_q) == num_q - TILE_W'(1));
  assign acc_ready = (state_q == WAIT_ACC);

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    num_d       = num_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_tiles;
          tile_d  = '0;
          state_d = (num_tiles == '0) ? FINISH : FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        bias_d  = rom_data;
        state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (acc_valid) begin
          out_data_d  = sum;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_tile) begin
            state_d = FINISH;
          end else begin
            tile_d  = tile_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == FETCH) || (state_d == LATCH) ||
                 (state_d == WAIT_ACC) || (state_d == OUTPUT);
    done_d     = (state_d == FINISH);
    rom_en_d   = (state_d == FETCH);
    rom_addr_d = rom_en_d ? tile_d : rom_addr_q;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tile_q      <= '0;
      num_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      num_q       <= num_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fc_bias_sequencer.sv
// tb_fc_bias_sequencer: directed bench for fc_bias_sequencer
// with a synchronous bias ROM model and negedge event monitors.
module tb_fc_bias_sequencer;

  localparam int NL = 16;
  localparam int AW = 32;
  localparam int VW = NL*AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [6:0]    num_tiles;
  logic          busy, done, rom_en;
  logic [5:0]    rom_addr;
  logic [VW-1:0] rom_data;
  logic          acc_valid, acc_ready;
  logic [VW-1:0] acc_data;
  logic          out_valid, out_ready;
  logic [VW-1:0] out_data;

  logic [VW-1:0] rom_mem [0:3];

  int checks = 0;
  int errors = 0;
  int n_rom, n_busy, n_done, n_acc_hs, n_out_hs, n_accrdy;
  int addrs[$];

  fc_bias_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data one cycle after rom_en
  always @(posedge clk)
    if (rom_en) rom_data <= rom_mem[rom_addr[1:0]];

  // event monitors sampled mid-cycle
  always @(negedge clk) begin
    if (rom_en) begin
      n_rom++;
      addrs.push_back(int'(rom_addr));
    end
    if (busy) n_busy++;
    if (done) n_done++;
    if (acc_ready) n_accrdy++;
    if (acc_valid && acc_ready) n_acc_hs++;
    if (out_valid && out_ready) n_out_hs++;
  end

  function automatic logic [VW-1:0] vec(input int base, input int stride);
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++)
      v[i*AW +: AW] = 32'(base + stride*i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_rom = 0; n_busy = 0; n_done = 0;
    n_acc_hs = 0; n_out_hs = 0; n_accrdy = 0;
    addrs.delete();
  endtask

  task automatic wait_ov(input string tag);
    for (int k = 0; k < 30 && !out_valid; k++) step();
    chk(tag, VW'(out_valid), VW'(1));
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && !done; k++) step();
    chk(tag, VW'(done), VW'(1));
    step();
  endtask

  logic [VW-1:0] w, held;

  initial begin
    rst_n = 1'b0; start = 1'b0; num_tiles = '0;
    acc_valid = 1'b0; acc_data = '0; out_ready = 1'b0;
    rom_data = '0;
    for (int t = 0; t < 4; t++) rom_mem[t] = '0;
    clr();
    step(); step();
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_rom_en", VW'(rom_en), '0);
    chk("rst_rom_addr", VW'(rom_addr), '0);
    chk("rst_acc_ready", VW'(acc_ready), '0);
    chk("rst_out_valid", VW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    step();

    // single tile, exact cycle timing
    clr();
    rom_mem[0] = vec(0, 10);
    acc_data = vec(100, 0);
    acc_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; num_tiles = 7'd1;
    step();
    start = 1'b0;
    chk("t1_fetch_rom_en", VW'(rom_en), VW'(1));
    chk("t1_fetch_addr", VW'(rom_addr), '0);
    chk("t1_fetch_busy", VW'(busy), VW'(1));
    chk("t1_fetch_acc_ready", VW'(acc_ready), '0);
    step();
    chk("t1_latch_rom_en", VW'(rom_en), '0);
    step();
    chk("t1_wait_acc_ready", VW'(acc_ready), VW'(1));
    step();
    chk("t1_out_valid", VW'(out_valid), VW'(1));
    chk("t1_out_data", out_data, vec(100, 10));
    step();
    chk("t1_done", VW'(done), VW'(1));
    chk("t1_busy_low", VW'(busy), '0);
    chk("t1_ov_drop", VW'(out_valid), '0);
    step();
    chk("t1_done_pulse", VW'(done), '0);
    chk("t1_n_rom", VW'(n_rom), VW'(1));
    chk("t1_n_busy", VW'(n_busy), VW'(4));
    chk("t1_n_done", VW'(n_done), VW'(1));
    chk("t1_n_out_hs", VW'(n_out_hs), VW'(1));
    acc_valid = 1'b0;

    // saturation on lanes 0 and 1
    w = vec(0, 10);
    w[31:0] = 32'h7FFF_FFF0;
    w[63:32] = 32'h8000_0010;
    rom_mem[0] = w;
    w = vec(100, 0);
    w[31:0] = 32'h0000_0100;
    w[63:32] = 32'hFFFF_FF00;
    acc_data = w;
    acc_valid = 1'b1;
    start = 1'b1; num_tiles = 7'd1;
    step();
    start = 1'b0;
    wait_ov("sat_timeout");
    w = vec(100, 10);
    w[31:0] = 32'h7FFF_FFFF;
    w[63:32] = 32'h8000_0000;
    chk("sat_out_data", out_data, w);
    wait_done("sat_done");
    acc_valid = 1'b0;

    // three tiles with 5-cycle backpressure each
    clr();
    for (int t = 0; t < 3; t++) rom_mem[t] = vec(t*1000, 1);
    acc_data = vec(5, 0);
    acc_valid = 1'b1; out_ready = 1'b0;
    start = 1'b1; num_tiles = 7'd3;
    step();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      wait_ov($sformatf("mt%0d_timeout", t));
      held = out_data;
      chk($sformatf("mt%0d_data", t), out_data, vec(t*1000 + 5, 1));
      for (int k = 0; k < 5; k++) step();
      chk($sformatf("mt%0d_stable", t), out_data, held);
      chk($sformatf("mt%0d_ov_held", t), VW'(out_valid), VW'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    wait_done("mt_done");
    step();
    chk("mt_n_addr", VW'(addrs.size()), VW'(3));
    for (int t = 0; t < 3 && t < addrs.size(); t++)
      chk($sformatf("mt_addr%0d", t), VW'(addrs[t]), VW'(t));
    chk("mt_n_out_hs", VW'(n_out_hs), VW'(3));
    chk("mt_n_done", VW'(n_done), VW'(1));

    // zero tiles
    clr();
    acc_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; num_tiles = 7'd0;
    step();
    start = 1'b0;
    chk("z_done", VW'(done), VW'(1));
    chk("z_busy", VW'(busy), '0);
    step();
    chk("z_done_pulse", VW'(done), '0);
    step();
    chk("z_n_rom", VW'(n_rom), '0);
    chk("z_n_accrdy", VW'(n_accrdy), '0);
    chk("z_n_busy", VW'(n_busy), '0);
    chk("z_n_done", VW'(n_done), VW'(1));

    // start while busy, acc_valid held from the start
    clr();
    rom_mem[1] = vec(7, 0);
    acc_valid = 1'b1; out_ready = 1'b1;
    start = 1'b1; num_tiles = 7'd2;
    step();
    start = 1'b0;
    chk("sb_acc_ready_fetch", VW'(acc_ready), '0);
    for (int k = 0; k < 30 && !(rom_en && rom_addr == 6'd1); k++) step();
    chk("sb_tile1_fetch", VW'(rom_en && rom_addr == 6'd1), VW'(1));
    start = 1'b1; num_tiles = 7'd5;
    step();
    start = 1'b0;
    wait_done("sb_done");
    step(); step(); step();
    chk("sb_idle_busy", VW'(busy), '0);
    chk("sb_n_acc_hs", VW'(n_acc_hs), VW'(2));
    chk("sb_n_out_hs", VW'(n_out_hs), VW'(2));
    chk("sb_n_rom", VW'(n_rom), VW'(2));
    chk("sb_n_done", VW'(n_done), VW'(1));

    // reset in OUTPUT of tile 1 of 4
    clr();
    for (int t = 0; t < 4; t++) rom_mem[t] = vec(t*1000, 1);
    acc_data = vec(5, 0);
    acc_valid = 1'b1; out_ready = 1'b0;
    start = 1'b1; num_tiles = 7'd4;
    step();
    start = 1'b0;
    wait_ov("rm_t0_timeout");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_ov("rm_t1_timeout");
    chk("rm_t1_addr", VW'(rom_addr), VW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_busy", VW'(busy), '0);
    chk("rm_out_valid", VW'(out_valid), '0);
    chk("rm_out_data", out_data, '0);
    chk("rm_rom_addr", VW'(rom_addr), '0);
    chk("rm_acc_ready", VW'(acc_ready), '0);
    chk("rm_done", VW'(done), '0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("rm_n_done", VW'(n_done), '0);
    chk("rm_idle_busy", VW'(busy), '0);
    clr();
    out_ready = 1'b1;
    start = 1'b1; num_tiles = 7'd1;
    step();
    start = 1'b0;
    wait_ov("rm_new_timeout");
    chk("rm_new_data", out_data, vec(5, 1));
    wait_done("rm_new_done");
    chk("rm_new_n_done", VW'(n_done), VW'(1));
    chk("rm_new_n_out_hs", VW'(n_out_hs), VW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
